// File: rtl/uart_tx_core.sv
// uart_tx_core: FIFO-buffered UART transmitter with a registered serial line.
// Define UART_TX_PARITY_EN to build the parity state and logic; otherwise PARITY is ignored.
module uart_tx_core #(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int PARITY       = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        txd,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PAR,
`endif
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        cnt;
    logic [2:0]           idx;
    logic [DATA_BITS-1:0] sh;
    logic [AW:0]          count_nxt;
    logic                 tick, last_stop, push, pop, line, unused_bits;
`ifdef UART_TX_PARITY_EN
    logic                 par;
`endif

    assign unused_bits = ^tx_data;
    assign tick        = (cnt == '0);
    assign last_stop   = (state == STOP) && tick && (idx == LAST_STOP);
    assign push        = tx_valid && tx_ready;
    // A new frame is fetched from IDLE or straight out of the final stop cycle.
    assign pop         = (fifo_count != '0) && ((state == IDLE) || last_stop);
    assign count_nxt   = fifo_count + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
`ifdef UART_TX_PARITY_EN
        line = (state == START) ? 1'b0 : (state == DATA) ? sh[0] : (state == PAR) ? par : 1'b1;
`else
        line = (state == START) ? 1'b0 : (state == DATA) ? sh[0] : 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= tx_data[DATA_BITS-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            sh         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tx_ready   <= 1'b0;
            txd        <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            txd        <= line;
            tx_busy    <= (state != IDLE);
            tx_done    <= last_stop;
            fifo_count <= count_nxt;
            tx_ready   <= (count_nxt != (AW+1)'(FIFO_DEPTH));
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                sh     <= mem[rd_ptr];
                state  <= START;
                cnt    <= CNT_MAX;
                idx    <= '0;
`ifdef UART_TX_PARITY_EN
                par    <= ^mem[rd_ptr] ^ (PARITY == 1);
`endif
            end else if (state != IDLE) begin
                cnt <= tick ? CNT_MAX : cnt - 1'b1;
                if (tick) begin
                    case (state)
                        START: begin
                            state <= DATA;
                            idx   <= '0;
                        end
                        DATA: begin
                            sh  <= sh >> 1;
                            idx <= (idx == LAST_DATA) ? '0 : idx + 1'b1;
`ifdef UART_TX_PARITY_EN
                            state <= (idx == LAST_DATA) ? ((PARITY != 0) ? PAR : STOP) : DATA;
                        end
                        PAR: begin
                            state <= STOP;
`else
                            state <= (idx == LAST_DATA) ? STOP : DATA;
`endif
                        end
                        default: begin
                            state <= (idx == LAST_STOP) ? IDLE : STOP;
                            idx   <= idx + 1'b1;
                        end
                    endcase
                end
            end
        end
    end
endmodule
